// File: rtl/bist_pkg.sv
// Shared definitions for the BIST host and the BIST controller.
//   bist_state_e  : 3-bit host FSM state encoding
//   ERR_*         : err_code values reported to the system sequencer
//   BURST_LEN_DEF : default cycles of mode=1 per burst
//   BURSTS_DEF    : default number of mode bursts per run
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_RUN       = 3'd3,
    ST_WAIT_END  = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } bist_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_INIT_TO = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_LEN     = 3'd3;
  localparam logic [2:0] ERR_COUNT   = 3'd4;
  localparam logic [2:0] ERR_END_TO  = 3'd5;

  localparam int BURST_LEN_DEF = 7;
  localparam int BURSTS_DEF    = 11;

endpackage

// File: rtl/bist_burst_meter.sv
// Burst meter for the BIST host: edge detection on mode, length of the
// burst in progress, saturating burst counter and the strict compare flags.
// Optional feature macro: BIST_HOST_STRICT_CHECK_EN (length/count compare).
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   clear         : start of a new run, zeroes the counters
//   enable        : host is in RUN; bursts are only measured there
//   mode          : controller status
//   burst_count   : registered, saturating count of recorded bursts
//   mode_edge     : mode differs from its value last cycle
//   len_bad       : falling edge this cycle and recorded length != BURST_LEN
//   count_bad     : count including this cycle's falling edge != BURSTS
module bist_burst_meter
  import bist_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int BURSTS    = BURSTS_DEF,
  parameter int BC_W      = $clog2(BURSTS + 2)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic            mode,
  output logic [BC_W-1:0] burst_count,
  output logic            mode_edge,
  output logic            len_bad,
  output logic            count_bad
);

`ifdef BIST_HOST_STRICT_CHECK_EN
  localparam bit STRICT_C = 1'b1;
`else
  localparam bit STRICT_C = 1'b0;
`endif

  localparam int              LW      = $clog2(BURST_LEN + 2);
  localparam logic [LW-1:0]   LEN_C   = LW'(BURST_LEN);
  localparam logic [LW-1:0]   LEN_ONE = LW'(1'b1);
  localparam logic [LW-1:0]   LEN_MAX = '1;
  localparam logic [BC_W-1:0] CNT_C   = BC_W'(BURSTS);
  localparam logic [BC_W-1:0] CNT_ONE = BC_W'(1'b1);
  localparam logic [BC_W-1:0] CNT_MAX = '1;

  logic            mode_q_r;
  logic [LW-1:0]   len_r;
  logic [BC_W-1:0] count_r;
  logic [BC_W-1:0] count_next_s;
  logic            rise_s;
  logic            fall_s;

  assign rise_s    = mode & ~mode_q_r;
  assign fall_s    = ~mode & mode_q_r;
  assign mode_edge = rise_s | fall_s;

  // Burst count after this cycle: a falling edge in RUN records one burst.
  always_comb begin
    count_next_s = count_r;
    if (enable && fall_s && (count_r != CNT_MAX)) begin
      count_next_s = count_r + CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Previous mode sample and the burst counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q_r <= 1'b0;
      count_r  <= '0;
    end else begin
      mode_q_r <= mode;
      if (clear) begin
        count_r <= '0;
      end else begin
        count_r <= count_next_s;
      end
    end
  end

  // Length of the burst in progress; a rising edge restarts it at 1.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      len_r <= '0;
    end else if (enable && rise_s) begin
      len_r <= LEN_ONE;
    end else if (enable && mode && (len_r != LEN_MAX)) begin
      len_r <= len_r + LEN_ONE;
    end else begin
      len_r <= len_r;
    end
  end

  // len_r still holds the finished burst's length on the falling-edge cycle.
  assign len_bad     = STRICT_C & enable & fall_s & (len_r != LEN_C);
  assign count_bad   = STRICT_C & (count_next_s != CNT_C);
  assign burst_count = count_r;

endmodule

// File: rtl/bist_host.sv
// BIST host: launches a BIST run on go, checks that the controller's status
// sequence (init, mode bursts, finish, bist_end) arrives in legal order and
// within TIMEOUT cycles per waiting phase, and reports the verdict.
// Optional feature macro: BIST_HOST_STRICT_CHECK_EN (burst length/count check).
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   go            : run request, honoured only in IDLE/DONE/ERROR
//   mode, bist_end, init, running, finish : controller status inputs
//   bist_start    : one-cycle start pulse to the controller
//   busy          : run in progress
//   done          : run concluded, held until the next accepted go
//   pass          : run concluded without error (valid with done)
//   err_code      : ERR_* code of the first detected error
//   burst_count   : bursts observed in the current/last run, saturating
module bist_host
  import bist_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int BURSTS    = BURSTS_DEF,
  parameter int TIMEOUT   = 1024,
  parameter int BC_W      = $clog2(BURSTS + 2)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            go,
  input  logic            mode,
  input  logic            bist_end,
  input  logic            init,
  input  logic            running,
  input  logic            finish,
  output logic            bist_start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [2:0]      err_code,
  output logic [BC_W-1:0] burst_count
);

  // One spare bit above TIMEOUT so the saturating timer can never wrap.
  localparam int            TW      = $clog2(TIMEOUT) + 2;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TM_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] TM_MAX  = '1;

  bist_state_e state_r, next_s;
  logic [TW-1:0] timer_r;
  logic [2:0]    err_code_r, err_set_s;
  logic          timer_clr_s, accept_s, timeout_s;
  logic          bist_start_r, busy_r, done_r, pass_r;
  logic          mode_edge_s, len_bad_s, count_bad_s;

  bist_burst_meter #(
    .BURST_LEN (BURST_LEN),
    .BURSTS    (BURSTS),
    .BC_W      (BC_W)
  ) u_meter (
    .clock       (clock),
    .reset       (reset),
    .clear       (accept_s),
    .enable      (state_r == ST_RUN),
    .mode        (mode),
    .burst_count (burst_count),
    .mode_edge   (mode_edge_s),
    .len_bad     (len_bad_s),
    .count_bad   (count_bad_s)
  );

  // The current cycle is the TIMEOUT-th one spent waiting in this phase.
  assign timeout_s = (timer_r >= TO_LAST);

  // Next state and error code; branch order encodes priority 2>3>4>5>1.
  always_comb begin
    next_s      = state_r;
    err_set_s   = ERR_NONE;
    timer_clr_s = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          next_s   = ST_START;
          accept_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      ST_START: begin
        next_s      = ST_WAIT_INIT;
        timer_clr_s = 1'b1;
      end
      ST_WAIT_INIT: begin
        if (mode || finish || bist_end) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_ORDER;
        end else if (init) begin
          next_s      = ST_RUN;
          timer_clr_s = 1'b1;
        end else if (timeout_s) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_INIT_TO;
        end else begin
          next_s = ST_WAIT_INIT;
        end
      end
      ST_RUN: begin
        if ((finish && mode) || init || bist_end || (mode && !running)) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_ORDER;
        end else if (len_bad_s) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_LEN;
        end else if (finish && count_bad_s) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_COUNT;
        end else if (finish) begin
          next_s      = ST_WAIT_END;
          timer_clr_s = 1'b1;
        end else if (mode_edge_s) begin
          next_s      = ST_RUN;
          timer_clr_s = 1'b1;
        end else if (timeout_s) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_END_TO;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_WAIT_END: begin
        if (init || mode) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_ORDER;
        end else if (bist_end) begin
          next_s = ST_DONE;
        end else if (timeout_s) begin
          next_s    = ST_ERROR;
          err_set_s = ERR_END_TO;
        end else begin
          next_s = ST_WAIT_END;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // Phase timer: cleared on phase entry and mode edges, saturating otherwise.
  always_ff @(posedge clock) begin
    if (reset || accept_s || timer_clr_s) begin
      timer_r <= '0;
    end else if (timer_r != TM_MAX) begin
      timer_r <= timer_r + TM_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end

  // State register and outputs, all derived from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bist_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_code_r   <= ERR_NONE;
    end else begin
      state_r      <= next_s;
      bist_start_r <= (next_s == ST_START);
      busy_r       <= (next_s inside {ST_START, ST_WAIT_INIT, ST_RUN, ST_WAIT_END});
      done_r       <= (next_s inside {ST_DONE, ST_ERROR});
      pass_r       <= (next_s == ST_DONE) && (err_code_r == ERR_NONE);
      if ((next_s == ST_ERROR) && (state_r != ST_ERROR)) begin
        err_code_r <= err_set_s;
      end else if (accept_s) begin
        err_code_r <= ERR_NONE;
      end else begin
        err_code_r <= err_code_r;
      end
    end
  end

  assign bist_start = bist_start_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_bist_host.sv
`timescale 1ns/1ps
module tb_bist_host;

  localparam int BURST_LEN = 7;
  localparam int BURSTS    = 11;
  localparam int TIMEOUT   = 16;
  localparam int BC_W      = $clog2(BURSTS + 2);
  localparam int CNT_MAX   = (1 << BC_W) - 1;
  localparam int TR_N      = 256;
`ifdef BIST_HOST_STRICT_CHECK_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct packed {
    logic init;
    logic mode;
    logic running;
    logic finish;
    logic bist_end;
  } stat_t;

  logic            clock = 1'b0;
  logic            reset, go, mode, bist_end, init, running, finish;
  logic            bist_start, busy, done, pass;
  logic [2:0]      err_code;
  logic [BC_W-1:0] burst_count;

  int    checks = 0;
  int    errors = 0;
  stat_t tr [TR_N];   // controller status, one entry per cycle after START
  int    run_hi;

  always #5 clock = ~clock;

  bist_host #(
    .BURST_LEN (BURST_LEN),
    .BURSTS    (BURSTS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .mode        (mode),
    .bist_end    (bist_end),
    .init        (init),
    .running     (running),
    .finish      (finish),
    .bist_start  (bist_start),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_code    (err_code),
    .burst_count (burst_count)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input stat_t s);
    init     = s.init;
    mode     = s.mode;
    running  = s.running;
    finish   = s.finish;
    bist_end = s.bist_end;
  endtask

  task automatic clear_tr();
    for (int i = 0; i < TR_N; i++) tr[i] = '0;
  endtask

  // Scripted controller: init, nb bursts (one possibly of short_len), finish, bist_end.
  task automatic build(input int init_dly, input int nb, input int short_idx,
                       input int short_len, input bit rnd, input bit no_init,
                       input bit no_fin, input bit no_end);
    int p;
    int len;
    int gap;
    clear_tr();
    p = init_dly;
    if (!no_init) tr[p].init = 1'b1;
    p++;
    gap = rnd ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < gap; i++) begin tr[p].running = 1'b1; p++; end
    for (int b = 0; b < nb; b++) begin
      len = (b == short_idx) ? short_len : BURST_LEN;
      for (int i = 0; i < len; i++) begin tr[p].mode = 1'b1; tr[p].running = 1'b1; p++; end
      if (b < nb - 1) gap = rnd ? int'($urandom_range(1, 3)) : 1;
      else            gap = rnd ? int'($urandom_range(0, 2)) : 1;
      for (int i = 0; i < gap; i++) begin tr[p].running = 1'b1; p++; end
    end
    if (!no_fin) begin tr[p].finish = 1'b1; p++; end
    run_hi = p;
    p += rnd ? int'($urandom_range(0, 3)) : 0;
    if (!no_end) tr[p].bist_end = 1'b1;
  endtask

  // Reference: walk the status trace through the phase rules and report the
  // trace index at which the verdict is reached, the code and the burst count.
  function automatic void model(output int k_out, output int code, output int cnt);
    int phase;
    int waited;
    int quiet;
    int len;
    bit prev_mode;
    bit rise;
    bit fall;
    stat_t c;
    phase = 0; waited = 0; quiet = 0; len = 0; prev_mode = 1'b0;
    k_out = -1; code = 0; cnt = 0;
    for (int k = 0; k < TR_N; k++) begin
      c = tr[k];
      if (phase == 0) begin
        waited++;
        if (c.mode || c.finish || c.bist_end) begin k_out = k; code = 2; return; end
        else if (c.init) begin phase = 1; quiet = 0; end
        else if (waited == TIMEOUT) begin k_out = k; code = 1; return; end
      end else if (phase == 1) begin
        rise = c.mode && !prev_mode;
        fall = !c.mode && prev_mode;
        if (c.mode) len = rise ? 1 : len + 1;
        if (fall && cnt < CNT_MAX) cnt++;
        if ((c.finish && c.mode) || c.init || c.bist_end || (c.mode && !c.running)) begin
          k_out = k; code = 2; return;
        end else if (STRICT && fall && len != BURST_LEN) begin
          k_out = k; code = 3; return;
        end else if (STRICT && c.finish && cnt != BURSTS) begin
          k_out = k; code = 4; return;
        end else if (c.finish) begin
          phase = 2; waited = 0;
        end else if (rise || fall) begin
          quiet = 0;
        end else begin
          quiet++;
          if (quiet == TIMEOUT) begin k_out = k; code = 5; return; end
        end
      end else begin
        waited++;
        if (c.init || c.mode) begin k_out = k; code = 2; return; end
        else if (c.bist_end) begin k_out = k; code = 0; return; end
        else if (waited == TIMEOUT) begin k_out = k; code = 5; return; end
      end
      prev_mode = c.mode;
    end
  endfunction

  // One run: go pulse (or held go), replay the trace, compare the verdict.
  task automatic run(input string tag, input bit hold_go, input int rst_at);
    int ek, ecode, ecnt, k, starts, falls;
    bit seen;
    model(ek, ecode, ecnt);
    go = 1'b1;
    drive('0);
    step();
    check({tag, "_start"}, bist_start, 1);
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_clear"}, {done, pass, err_code, burst_count}, 0);
    go = hold_go;
    step();
    check({tag, "_start_low"}, bist_start, 0);
    starts = 0; seen = 1'b0; k = 0;
    while (!seen && k < TR_N) begin
      if (k == rst_at) begin
        falls = 0;
        for (int i = 1; i < rst_at; i++) if (tr[i-1].mode && !tr[i].mode) falls++;
        check({tag, "_pre_rst_count"}, burst_count, falls);
        reset = 1'b1;
        drive(tr[k]);
        step();
        reset = 1'b0;
        drive('0);
        go = 1'b0;
        check({tag, "_rst_outs"}, {bist_start, busy, done, pass, err_code, burst_count}, 0);
        return;
      end
      drive(tr[k]);
      step();
      if (bist_start) starts++;
      if (done) seen = 1'b1;
      else k++;
    end
    drive('0);
    check({tag, "_done_cycle"}, seen ? k : -1, ek);
    check({tag, "_code"}, err_code, ecode);
    check({tag, "_pass"}, pass, (ecode == 0) ? 1 : 0);
    check({tag, "_count"}, burst_count, ecnt);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_extra_start"}, starts, 0);
    if (hold_go) begin
      step();
      check({tag, "_restart"}, bist_start, 1);
      go = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check({tag, "_cleanup"}, {bist_start, busy, done}, 0);
    end else begin
      go = 1'b0;
    end
  endtask

  initial begin
    int sel, pos;
    reset = 1'b1;
    go    = 1'b1;
    drive('0);
    step();
    step();
    check("rst_outs", {bist_start, busy, done, pass, err_code, burst_count}, 0);
    reset = 1'b0;
    go    = 1'b0;
    step();
    check("rst_go_ignored", {bist_start, busy, done}, 0);

    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    run("nom", 1'b0, -1);
    check("nom_code_c", err_code, 0);
    check("nom_pass_c", pass, 1);
    check("nom_count_c", burst_count, BURSTS);

    clear_tr();
    run("init_to", 1'b0, -1);
    check("init_to_code_c", err_code, 1);

    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    tr[20].bist_end = 1'b1;
    run("order", 1'b0, -1);
    check("order_code_c", err_code, 2);

    build(0, BURSTS, 2, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    run("short", 1'b0, -1);
    check("short_code_c", err_code, STRICT ? 3 : 0);

    build(0, BURSTS - 1, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    run("ten", 1'b0, -1);
    check("ten_code_c", err_code, STRICT ? 4 : 0);
    check("ten_count_c", burst_count, BURSTS - 1);

    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b1);
    run("end_to", 1'b0, -1);
    check("end_to_code_c", err_code, 5);

    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b1, 1'b1);
    run("run_to", 1'b0, -1);
    check("run_to_code_c", err_code, 5);

    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    run("midrst", 1'b0, 34);
    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    run("after_rst", 1'b0, -1);
    check("after_rst_count_c", burst_count, BURSTS);

    build(0, BURSTS, -1, BURST_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    run("hold", 1'b1, -1);

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 99));
      build(int'($urandom_range(0, 4)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 12)) : BURSTS,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1,
            ($urandom_range(0, 1) == 0) ? 6 : 8,
            1'b1, sel < 4, (sel >= 4) && (sel < 8), (sel >= 8) && (sel < 12));
      if (sel >= 70) begin
        pos = int'($urandom_range(0, run_hi + 2));
        case ($urandom_range(0, 4))
          0: tr[pos].init     = 1'b1;
          1: tr[pos].bist_end = 1'b1;
          2: tr[pos].mode     = ~tr[pos].mode;
          3: tr[pos].running  = 1'b0;
          default: tr[pos].finish = 1'b1;
        endcase
      end
      run("rnd", 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
